// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared receiver/transmitter types, parity modes, oversample rate
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVS      = 16;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_DELIVER  = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : one-cycle tick every TICK_DIV clocks while en is high
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// uart_rx_cfg : configurable 16x oversampled UART receiver with valid/ready out
// Option      : define UART_RX_BREAK_DET_EN to enable line-break detection
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int TICK_DIV  = 651,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_busy
);

    state_t                 state_q;
    logic                   rx_s1_q, rx_s2_q, rx_s3_q;
    logic [3:0]             ovs_q;
    logic [3:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   smp_a_q, smp_b_q;
    logic                   ferr_q, perr_q;
    logic                   tick, rx_fall, bit_maj, at_mid, at_end, par_calc;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != S_IDLE),
        .tick (tick)
    );

    assign rx_fall  = rx_s3_q & ~rx_s2_q;
    assign bit_maj  = maj3(smp_a_q, smp_b_q, rx_s2_q);
    assign at_mid   = tick && (ovs_q == 4'd9);
    assign at_end   = tick && (ovs_q == 4'(OVS - 1));
    assign par_calc = (^shreg_q) ^ bit_maj;
    assign o_busy   = (state_q != S_IDLE);

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q, brk_q, brk_hit;
    assign brk_hit = (shreg_q == '0) && !par_bit_q && !bit_maj;
    assign o_break = brk_q;
`else
    assign o_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            ovs_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            smp_a_q      <= 1'b0;
            smp_b_q      <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q    <= 1'b0;
            brk_q        <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            o_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q     <= 1'b0;
`endif
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            // Ticks 7 and 8 are stored; tick 9 votes with the live sample.
            if (tick) begin
                if (ovs_q == 4'd7) smp_a_q <= rx_s2_q;
                if (ovs_q == 4'd8) smp_b_q <= rx_s2_q;
                ovs_q <= ovs_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        state_q   <= S_START;
                        ovs_q     <= '0;
                        bit_cnt_q <= '0;
                        ferr_q    <= 1'b0;
                        perr_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (at_mid && bit_maj) begin
                        state_q <= S_IDLE;
                    end else if (at_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_mid) begin
                        shreg_q <= {bit_maj, shreg_q[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_mid) begin
                        perr_q <= (PARITY == PAR_ODD) ? ~par_calc : par_calc;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= bit_maj;
`endif
                    end
                    if (at_end) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_mid) begin
                        if (!bit_maj) ferr_q <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        if (bit_cnt_q == 4'd0 && brk_hit) begin
                            brk_q   <= 1'b1;
                            state_q <= S_BRK_WAIT;
                        end else
`endif
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            state_q <= S_DELIVER;
                        end
                    end else if (at_end) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (o_valid && !i_ready) begin
                        o_overrun <= 1'b1;
                    end else begin
                        o_data       <= shreg_q;
                        o_frame_err  <= ferr_q;
                        o_parity_err <= perr_q;
                        o_valid      <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                S_BRK_WAIT: begin
`ifdef UART_RX_BREAK_DET_EN
                    if (rx_s2_q) state_q <= S_IDLE;
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// tb_uart_rx_cfg : directed bench for uart_rx_cfg (8N1 and 8E1 instances)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1, rx_p = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data, p_data;
    logic       o_valid, o_frame_err, o_parity_err, o_overrun, o_break, o_busy;
    logic       p_valid, p_frame_err, p_parity_err, p_overrun, p_break, p_busy;

    int checks = 0;
    int errors = 0;

    int         vld_cyc = 0, acc_cnt = 0, ovr_cnt = 0, brk_cnt = 0, p_acc_cnt = 0;
    logic [7:0] last_data = '0, p_last_data = '0;
    logic       last_ferr = 1'b0, last_perr = 1'b0, p_last_ferr = 1'b0, p_last_perr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.TICK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_overrun(o_overrun),
        .o_break(o_break), .o_busy(o_busy)
    );

    uart_rx_cfg #(.TICK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .o_data(p_data), .o_valid(p_valid), .i_ready(1'b1),
        .o_frame_err(p_frame_err), .o_parity_err(p_parity_err), .o_overrun(p_overrun),
        .o_break(p_break), .o_busy(p_busy)
    );

    always @(negedge clk) begin
        if (o_valid) vld_cyc <= vld_cyc + 1;
        if (o_overrun) ovr_cnt <= ovr_cnt + 1;
        if (o_break) brk_cnt <= brk_cnt + 1;
        if (o_valid && i_ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_data <= o_data;
            last_ferr <= o_frame_err;
            last_perr <= o_parity_err;
        end
        if (p_valid) begin
            p_acc_cnt   <= p_acc_cnt + 1;
            p_last_data <= p_data;
            p_last_ferr <= p_frame_err;
            p_last_perr <= p_parity_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input bit sel, input logic v, input int n);
        if (sel) rx_p = v; else rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic frame(input bit sel, input logic [7:0] d, input bit has_par, input logic pb);
        line(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) line(sel, d[i], BIT);
        if (has_par) line(sel, pb, BIT);
        line(sel, 1'b1, BIT);
    endtask

    int acc0, vld0, ovr0, brk0, pacc0;

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_perr", o_parity_err, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_brk", o_break, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;
        line(0, 1'b1, 20);

        // 8N1 0xA5 with ready high
        acc0 = acc_cnt; vld0 = vld_cyc;
        frame(0, 8'hA5, 0, 1'b0);
        line(0, 1'b1, 8);
        @(negedge clk);
        chk("a5_acc", acc_cnt - acc0, 1);
        chk("a5_vld_cycles", vld_cyc - vld0, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_ferr", last_ferr, 0);
        chk("a5_perr", last_perr, 0);

        // even parity: 0x07 has three ones, correct parity bit is 1
        pacc0 = p_acc_cnt;
        frame(1, 8'h07, 1, 1'b0);
        line(1, 1'b1, 8);
        @(negedge clk);
        chk("par_acc", p_acc_cnt - pacc0, 1);
        chk("par_data", p_last_data, 8'h07);
        chk("par_perr", p_last_perr, 1);
        chk("par_ferr", p_last_ferr, 0);
        frame(1, 8'h07, 1, 1'b1);
        line(1, 1'b1, 8);
        @(negedge clk);
        chk("par_ok_data", p_last_data, 8'h07);
        chk("par_ok_perr", p_last_perr, 0);

        // 20-clk glitch
        acc0 = acc_cnt;
        line(0, 1'b0, 10);
        @(negedge clk);
        chk("glitch_busy_hi", o_busy, 1);
        line(0, 1'b0, 10);
        line(0, 1'b1, 32);
        @(negedge clk);
        chk("glitch_busy_lo", o_busy, 0);
        chk("glitch_no_valid", acc_cnt - acc0, 0);
        line(0, 1'b1, 40);

        // line held low for 12 bit times
        acc0 = acc_cnt; brk0 = brk_cnt;
        line(0, 1'b0, 12 * BIT);
        line(0, 1'b1, 2 * BIT);
        @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_pulse", brk_cnt - brk0, 1);
        chk("brk_no_valid", acc_cnt - acc0, 0);
`else
        chk("brk_pulse", brk_cnt - brk0, 0);
        chk("brk_acc", acc_cnt - acc0, 1);
        chk("brk_data", last_data, 8'h00);
        chk("brk_ferr", last_ferr, 1);
`endif
        chk("brk_busy", o_busy, 0);

        // overrun: 0x11 then 0x22 back-to-back with ready low
        i_ready = 1'b0;
        ovr0 = ovr_cnt;
        frame(0, 8'h11, 0, 1'b0);
        frame(0, 8'h22, 0, 1'b0);
        line(0, 1'b1, 8);
        @(negedge clk);
        chk("ovr_valid", o_valid, 1);
        chk("ovr_data", o_data, 8'h11);
        chk("ovr_ferr", o_frame_err, 0);
        chk("ovr_pulses", ovr_cnt - ovr0, 1);
        #1 i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_cleared", o_valid, 0);

        // reset in the middle of a frame
        i_ready = 1'b0;
        frame(0, 8'h96, 0, 1'b0);
        line(0, 1'b1, 8);
        @(negedge clk);
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_data", o_data, 8'h96);
        line(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) line(0, (8'h5A >> i) & 1, BIT);
        rx = 1'b1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_data", o_data, 8'h00);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ferr", o_frame_err, 0);
        chk("mid_rst_ovr", o_overrun, 0);
        line(0, 1'b0, BIT - 10);
        line(0, 1'b1, BIT);
        line(0, 1'b0, BIT);
        line(0, 1'b1, BIT);
        rst = 1'b0;
        i_ready = 1'b1;
        line(0, 1'b1, BIT);
        acc0 = acc_cnt;
        frame(0, 8'h3C, 0, 1'b0);
        line(0, 1'b1, 8);
        @(negedge clk);
        chk("post_rst_acc", acc_cnt - acc0, 1);
        chk("post_rst_data", last_data, 8'h3C);
        chk("post_rst_ferr", last_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
